// File: rtl/pipe_ctrl.sv
// Sequencer beside the 5-stage mips32 pipeline: program load, run/halt control,
// RAW-hazard stalls from a destination scoreboard and wrong-path squash on taken branches.
//
// state  | meaning
// IDLE   | waiting for load_start / run_start
// LOAD   | accepting program words into instruction memory
// RUN    | pipeline executing; hazards stall, taken branches squash
// DRAIN  | HALT seen; fetch frozen until in-flight writers retire
// HALTED | run finished (done or timeout), flags and counters held
module pipe_ctrl #(
    parameter int          IMEM_AW    = 10,
    parameter int          SB_DEPTH   = 4,
    parameter logic [31:0] MAX_CYCLES = 32'hFFFFF,
    parameter logic [5:0]  HALT_OP    = 6'b111111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               prog_valid,
    output logic               prog_ready,
    input  logic [31:0]        prog_data,
    input  logic               prog_last,
    input  logic               run_start,
    input  logic [31:0]        id_ir,
    input  logic               ex_taken,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               pc_clr,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               load_full,
    output logic [31:0]        cycle_cnt,
    output logic [15:0]        stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t                     state_q, state_d;
    logic [IMEM_AW-1:0]         wptr_q, wptr_d;
    logic                       load_full_q, load_full_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;
    logic [31:0]                cycle_cnt_q, cycle_cnt_d;
    logic [15:0]                stall_cnt_q, stall_cnt_d;
    logic                       id_vld_q, id_vld_d;
    logic [SB_DEPTH-1:0]        sb_v_q, sb_v_d;
    logic [SB_DEPTH-1:0][4:0]   sb_rd_q, sb_rd_d;

    logic [5:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       is_halt, writes_rd, use_rs1, use_rs2, use_rd;
    logic       hazard_raw, hazard, sb_empty;
    logic       issue, sb_shift;
    logic       unused_ir;

    assign op        = id_ir[31:26];
    assign rd        = id_ir[25:21];
    assign rs1       = id_ir[20:16];
    assign rs2       = id_ir[15:11];
    assign unused_ir = ^id_ir[10:0];

    assign is_halt   = (op == HALT_OP);
    assign writes_rd = ~op[5] | (op == 6'b110000);
    assign use_rs1   = ~is_halt;
    assign use_rs2   = ~op[5] & ~op[4];
    assign use_rd    = (op == 6'b110001);

    // No forwarding: any in-flight writer of a source register blocks issue.
    always_comb begin
        hazard_raw = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_v_q[i]) begin
                if (use_rs1 && sb_rd_q[i] == rs1) hazard_raw = 1'b1;
                if (use_rs2 && sb_rd_q[i] == rs2) hazard_raw = 1'b1;
                if (use_rd  && sb_rd_q[i] == rd)  hazard_raw = 1'b1;
            end
        end
    end

    assign hazard   = id_vld_q & hazard_raw;
    assign sb_empty = ~|sb_v_q;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        load_full_d = load_full_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        id_vld_d    = id_vld_q;
        sb_v_d      = sb_v_q;
        sb_rd_d     = sb_rd_q;
        prog_ready  = 1'b0;
        imem_we     = 1'b0;
        imem_waddr  = '0;
        imem_wdata  = '0;
        pc_clr      = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        issue       = 1'b0;
        sb_shift    = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (load_start) begin
                    state_d     = S_LOAD;
                    wptr_d      = '0;
                    load_full_d = 1'b0;
                end else if (run_start) begin
                    state_d     = S_RUN;
                    pc_clr      = 1'b1;
                    cycle_cnt_d = '0;
                    stall_cnt_d = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    id_vld_d    = 1'b0;
                    sb_v_d      = '0;
                    sb_rd_d     = '0;
                end
            end

            S_LOAD: begin
                prog_ready = 1'b1;
                if (prog_valid) begin
                    imem_we    = 1'b1;
                    imem_waddr = wptr_q;
                    imem_wdata = prog_data;
                    wptr_d     = wptr_q + 1'b1;
                    if (prog_last) begin
                        state_d = S_IDLE;
                    end else if (wptr_q == {IMEM_AW{1'b1}}) begin
                        state_d     = S_IDLE;
                        load_full_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                sb_shift = 1'b1;
                if (cycle_cnt_q == MAX_CYCLES) begin
                    state_d   = S_HALTED;
                    timeout_d = 1'b1;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                    if (ex_taken) begin
                        // Anything in IF/ID (including a HALT) is wrong-path here.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        pc_en      = 1'b1;
                    end else if (hazard) begin
                        idex_flush = 1'b1;
                        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
                    end else if (id_vld_q && is_halt) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        state_d    = S_DRAIN;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        issue   = id_vld_q;
                    end
                    if (ifid_flush)   id_vld_d = 1'b0;
                    else if (ifid_en) id_vld_d = 1'b1;
                end
            end

            S_DRAIN: begin
                sb_shift    = 1'b1;
                idex_flush  = 1'b1;
                cycle_cnt_d = cycle_cnt_q + 32'd1;
                if (sb_empty) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (sb_shift) begin
            for (int i = SB_DEPTH - 1; i > 0; i--) begin
                sb_v_d[i]  = sb_v_q[i-1];
                sb_rd_d[i] = sb_rd_q[i-1];
            end
            sb_v_d[0]  = issue & writes_rd;
            sb_rd_d[0] = issue ? rd : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            load_full_q <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            id_vld_q    <= 1'b0;
            sb_v_q      <= '0;
            sb_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            load_full_q <= load_full_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            id_vld_q    <= id_vld_d;
            sb_v_q      <= sb_v_d;
            sb_rd_q     <= sb_rd_d;
        end
    end

    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign load_full = load_full_q;
    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
